// File: rtl/aoi_pkg.sv
// Shared definitions for the AOI22/OAI22 bank: mode encodings, the per-bit
// gate function and the snapshot handshake state type.
package aoi_pkg;

  localparam logic MODE_AOI = 1'b0;
  localparam logic MODE_OAI = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  // One bit of the compound gate: AOI22 or OAI22 selected by mode.
  function automatic logic aoi_eval(input logic mode, input logic a, input logic b,
                                    input logic c, input logic d);
    if (mode == MODE_OAI) return ~((a | b) & (c | d));
    else                  return ~((a & b) | (c & d));
  endfunction

endpackage

// File: rtl/aoi22_bank_actmon_cnt.sv
// One channel of the activity monitor: saturating toggle counter with a sticky
// overflow flag. A clear on the same edge as a toggle leaves the count at one.
module actmon_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count: clear (load-one on a coincident toggle), else saturating increment.
  // The flag marks a toggle that arrived while the count was already pinned at max.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/aoi22_bank_actmon.sv
// WIDTH-channel registered AOI22/OAI22 bank with per-channel toggle counters
// on the last pipeline stage, read back through a req/ack snapshot.
// Handshake: SNAP_REQ is a level; while idle, REQ high at an edge captures the
// counters and raises SNAP_ACK, which stays high until an edge sees REQ low.
module aoi22_bank_actmon
  import aoi_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic                                     CLK,
  input  logic                                     RSTB,
  input  logic                                     EN,
  input  logic                                     MODE,
  input  logic [WIDTH-1:0]                         IN1,
  input  logic [WIDTH-1:0]                         IN2,
  input  logic [WIDTH-1:0]                         IN3,
  input  logic [WIDTH-1:0]                         IN4,
  output logic [WIDTH-1:0]                         QN,
  input  logic                                     SNAP_REQ,
  output logic                                     SNAP_ACK,
  input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] RD_SEL,
  output logic [CNT_W-1:0]                         RD_DATA,
  output logic                                     OVF,
  output state_e                                   DBG_STATE
);

  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] pipe_q [STAGES];
  logic [WIDTH-1:0] pipe_d [STAGES];
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] ovf_vec;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] snap_q [WIDTH];
  logic [CNT_W-1:0] snap_d [WIDTH];
  state_e           state_q, state_d;
  logic             capture;

  // Per-channel gate evaluation; MODE is taken together with the data inputs.
  always_comb begin
    f = '0;
    for (int i = 0; i < WIDTH; i++) f[i] = aoi_eval(MODE, IN1[i], IN2[i], IN3[i], IN4[i]);
  end

  // Pipeline shift when enabled, otherwise every stage holds.
  always_comb begin
    pipe_d = pipe_q;
    if (EN) begin
      pipe_d[0] = f;
      for (int s = 1; s < STAGES; s++) pipe_d[s] = pipe_q[s-1];
    end
  end

  // Pipeline registers; reset to the AOI output for all-zero inputs.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int s = 0; s < STAGES; s++) pipe_q[s] <= '1;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign QN  = pipe_q[STAGES-1];
  // Stages only move with EN, so this is already zero on stalled edges.
  assign tog = pipe_d[STAGES-1] ^ pipe_q[STAGES-1];

  // Snapshot handshake next-state: capture on entry to ACK, wait for REQ to drop.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (SNAP_REQ) begin
        capture = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK:  if (!SNAP_REQ) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign SNAP_ACK  = (state_q == ST_ACK);
  assign DBG_STATE = state_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
    actmon_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (CLK),
      .rst_n (RSTB),
      .inc   (tog[g]),
      .clr   (capture),
      .cnt   (cnt[g]),
      .ovf   (ovf_vec[g])
    );
  end

  // Snapshot takes the pre-edge live counts on a capture edge.
  always_comb begin
    snap_d = snap_q;
    if (capture) snap_d = cnt;
  end

  // Snapshot registers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < WIDTH; i++) snap_q[i] <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  // Read mux; select codes past the last channel return zero.
  always_comb begin
    RD_DATA = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (RD_SEL == SEL_W'(i)) RD_DATA = snap_q[i];
    end
  end

  assign OVF = |ovf_vec;

endmodule

// File: tb/tb_aoi22_bank_actmon.sv
// Bench for aoi22_bank_actmon: two instances share stimulus (16-bit and 2-bit
// counters, both two stages deep) and are compared against a queue-based model.
module tb_aoi22_bank_actmon;
  import aoi_pkg::*;

  localparam int W  = 8;
  localparam int ST = 2;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 3;

  logic         clk, rstb, en, mode, req;
  logic [W-1:0] in1, in2, in3, in4;
  logic [2:0]   rd_sel;
  logic [W-1:0] qn_a, qn_b;
  logic         ack_a, ack_b, ovf_a, ovf_b;
  logic [15:0]  rd_a;
  logic [1:0]   rd_b;
  state_e       dbg_a, dbg_b;

  aoi22_bank_actmon #(.WIDTH(W), .STAGES(ST), .CNT_W(16)) dut_a (
    .CLK(clk), .RSTB(rstb), .EN(en), .MODE(mode), .IN1(in1), .IN2(in2), .IN3(in3),
    .IN4(in4), .QN(qn_a), .SNAP_REQ(req), .SNAP_ACK(ack_a), .RD_SEL(rd_sel),
    .RD_DATA(rd_a), .OVF(ovf_a), .DBG_STATE(dbg_a));

  aoi22_bank_actmon #(.WIDTH(W), .STAGES(ST), .CNT_W(2)) dut_b (
    .CLK(clk), .RSTB(rstb), .EN(en), .MODE(mode), .IN1(in1), .IN2(in2), .IN3(in3),
    .IN4(in4), .QN(qn_b), .SNAP_REQ(req), .SNAP_ACK(ack_b), .RD_SEL(rd_sel),
    .RD_DATA(rd_b), .OVF(ovf_b), .DBG_STATE(dbg_b));

  // Clock / reset block
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: exp_q holds the in-flight pipeline contents, oldest first.
  logic [W-1:0] exp_q[$];
  int m_cnt_a[W], m_cnt_b[W], m_snap_a[W], m_snap_b[W];
  bit m_ovf_a[W], m_ovf_b[W];
  bit m_ack;

  typedef struct {
    logic         mode;
    logic [W-1:0] a, b, c, d;
    logic [W-1:0] exp_qn;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gate(input logic m, input logic [W-1:0] a, b, c, d);
    return m ? ~((a | b) & (c | d)) : ~((a & b) | (c & d));
  endfunction

  function automatic bit any_ovf(input bit v[W]);
    bit r = 0;
    for (int i = 0; i < W; i++) r |= v[i];
    return r;
  endfunction

  task automatic model_reset();
    exp_q = {};
    for (int s = 0; s < ST; s++) exp_q.push_back('1);
    for (int i = 0; i < W; i++) begin
      m_cnt_a[i] = 0; m_cnt_b[i] = 0; m_snap_a[i] = 0; m_snap_b[i] = 0;
      m_ovf_a[i] = 0; m_ovf_b[i] = 0;
    end
    m_ack = 0;
  endtask

  // One edge of the model, from the inputs currently driven.
  task automatic model_edge();
    logic [W-1:0] old_qn, new_qn;
    bit cap;
    old_qn = exp_q[0];
    if (en) begin
      exp_q.push_back(gate(mode, in1, in2, in3, in4));
      void'(exp_q.pop_front());
    end
    new_qn = exp_q[0];
    cap = !m_ack && req;
    for (int i = 0; i < W; i++) begin
      bit t = (old_qn[i] != new_qn[i]);
      if (cap) begin
        m_snap_a[i] = m_cnt_a[i]; m_snap_b[i] = m_cnt_b[i];
        m_cnt_a[i] = t ? 1 : 0;   m_cnt_b[i] = t ? 1 : 0;
        m_ovf_a[i] = 0;           m_ovf_b[i] = 0;
      end else if (t) begin
        if (m_cnt_a[i] == MAX_A) m_ovf_a[i] = 1; else m_cnt_a[i]++;
        if (m_cnt_b[i] == MAX_B) m_ovf_b[i] = 1; else m_cnt_b[i]++;
      end
    end
    if (!m_ack && req) m_ack = 1;
    else if (m_ack && !req) m_ack = 0;
  endtask

  // Driver: advance one edge and compare everything observable against the model.
  task automatic tick();
    int s;
    model_edge();
    @(posedge clk);
    #1;
    s = $urandom_range(0, W - 1);
    rd_sel = 3'(s);
    #1;
    chk("qn_a", qn_a, exp_q[0]);
    chk("qn_b", qn_b, exp_q[0]);
    chk("ack_a", ack_a, m_ack);
    chk("ack_b", ack_b, m_ack);
    chk("dbg_a", dbg_a, m_ack);
    chk("dbg_b", dbg_b, m_ack);
    chk("ovf_a", ovf_a, any_ovf(m_ovf_a));
    chk("ovf_b", ovf_b, any_ovf(m_ovf_b));
    chk("rd_a", rd_a, m_snap_a[s]);
    chk("rd_b", rd_b, m_snap_b[s]);
  endtask

  task automatic capture();
    req = 1'b1;
    tick();
    chk("cap_ack_hi", ack_a, 1);
    req = 1'b0;
    tick();
    chk("cap_ack_lo", ack_a, 0);
  endtask

  task automatic read(input int sel, output longint va, output longint vb);
    rd_sel = 3'(sel);
    #1;
    va = rd_a;
    vb = rd_b;
  endtask

  task automatic set_in(input logic m, input logic [W-1:0] a, b, c, d);
    mode = m; in1 = a; in2 = b; in3 = c; in4 = d;
  endtask

  initial begin
    longint va, vb;
    logic [W-1:0] held;

    vecs[0] = '{MODE_AOI, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'hF0};
    vecs[1] = '{MODE_OAI, 8'h01, 8'h00, 8'h01, 8'h00, 8'hFE};
    vecs[2] = '{MODE_AOI, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    vecs[3] = '{MODE_OAI, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[4] = '{MODE_AOI, 8'hAA, 8'hFF, 8'h55, 8'h0F, 8'h50};
    vecs[5] = '{MODE_OAI, 8'hF0, 8'h00, 8'h00, 8'h3C, 8'hCF};

    // Reset state
    rstb = 1'b0; en = 1'b1; req = 1'b0; rd_sel = 3'd0;
    set_in(MODE_AOI, 8'h0F, 8'h0F, 8'h00, 8'h00);
    model_reset();
    #25;
    chk("rst_qn", qn_a, 8'hFF);
    chk("rst_ack", ack_a, 0);
    chk("rst_ovf", ovf_a, 0);
    read(5, va, vb);
    chk("rst_rd", va, 0);
    @(negedge clk);
    rstb = 1'b1;

    // Latency: two enabled edges to reach QN
    tick();
    chk("lat_edge1", qn_a, 8'hFF);
    tick();
    chk("lat_edge2", qn_a, 8'hF0);

    // Gate truth table in both modes
    for (int v = 0; v < 6; v++) begin
      set_in(vecs[v].mode, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
      for (int k = 0; k < ST; k++) tick();
      chk($sformatf("vec%0d_a", v), qn_a, vecs[v].exp_qn);
      chk($sformatf("vec%0d_b", v), qn_b, vecs[v].exp_qn);
    end

    // Stall: EN low freezes QN while inputs move
    set_in(MODE_OAI, 8'h01, 8'h00, 8'h01, 8'h00);
    for (int k = 0; k < ST; k++) tick();
    chk("oai_qn0", qn_a[0], 0);
    held = qn_a;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      chk("stall_qn", qn_a, held);
    end
    en = 1'b1;

    // Count 10 toggles on channel 3
    set_in(MODE_AOI, 8'h00, 8'h08, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) tick();
    capture();
    for (int k = 0; k < 10; k++) begin
      in1[3] = ~in1[3];
      tick();
    end
    for (int k = 0; k < 3; k++) tick();
    capture();
    read(3, va, vb);
    chk("cnt10_a", va, 10);
    chk("cnt10_b", vb, 3);
    for (int s = 0; s < W; s++) begin
      if (s != 3) begin
        read(s, va, vb);
        chk("cnt_other", va, 0);
      end
    end
    capture();
    for (int s = 0; s < W; s++) begin
      read(s, va, vb);
      chk("live_cleared", va, 0);
    end

    // Toggle on the capture edge lands in the new live count
    set_in(MODE_AOI, 8'h01, 8'h01, 8'h00, 8'h00);
    tick();
    req = 1'b1;
    tick();
    chk("sim_ack", ack_a, 1);
    req = 1'b0;
    tick();
    read(0, va, vb);
    chk("sim_snap0", va, 0);
    capture();
    read(0, va, vb);
    chk("sim_live_a", va, 1);
    chk("sim_live_b", vb, 1);

    // Saturation of the 2-bit counter on channel 5
    in2 = 8'h21;
    tick();
    for (int k = 0; k < 5; k++) begin
      in1[5] = ~in1[5];
      tick();
    end
    for (int k = 0; k < 3; k++) tick();
    chk("sat_ovf_b", ovf_b, 1);
    chk("sat_ovf_a", ovf_a, 0);
    capture();
    read(5, va, vb);
    chk("sat_rd_a", va, 5);
    chk("sat_rd_b", vb, 3);
    chk("sat_ovf_clr", ovf_b, 0);

    // Reset in the middle of a handshake
    req = 1'b1;
    tick();
    chk("mid_ack", ack_a, 1);
    #1;
    rstb = 1'b0;
    model_reset();
    #1;
    chk("mid_ack_drop_a", ack_a, 0);
    chk("mid_ack_drop_b", ack_b, 0);
    read(5, va, vb);
    chk("mid_snap_a", va, 0);
    chk("mid_snap_b", vb, 0);
    chk("mid_qn", qn_a, 8'hFF);
    #2;
    rstb = 1'b1;
    tick();
    chk("mid_reack", ack_a, 1);
    req = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      set_in(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) req = ~req;
      tick();
    end
    req = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
